sv_port_list_splitter: RTL
==========================

# sv_port_list_splitter

- Streaming front-end for hardware-assisted prototype parsing.
- Consumes a byte stream of SystemVerilog source positioned at or before a module's port list `( ... )`.
- Emits each top-level port declaration as a separate byte segment, with whitespace normalised, plus a port count.
- Sits directly upstream of the port-declaration parser, which receives one segment per port with an end marker and index.

## Interface
- `DEPTH_W`, default 4: nesting-depth counter width; maximum depth is 2^DEPTH_W−1.
- `CNT_W`, default 8: width of the port index and port count.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input byte valid.
- `s_ready` out 1: input byte accepted when `s_valid && s_ready`.
- `s_data` in 8: ASCII byte.
- `s_last` in 1: final byte of the source stream.
- `m_valid` out 1: output byte valid.
- `m_ready` in 1: downstream accepts the output byte.
- `m_data` out 8: port-text byte.
- `m_last` out 1: last byte of the current port segment.
- `m_idx` out CNT_W: zero-based index of the port this byte belongs to.
- `done` out 1: one-cycle pulse when the list is fully emitted.
- `port_count` out CNT_W: number of segments emitted; valid while `done` is high and held until the next list.
- `err` out 1: sticky error flag; cleared only by reset.

## Operation
- **States:** WAIT_OPEN, IN_LIST, SPACE_STALL, FLUSH, TAIL.
- **WAIT_OPEN:**
  - Bytes are discarded.
  - `(` sets depth=1, idx=0, clears the hold register and moves to IN_LIST.
- **Whitespace:** 0x20, 0x09, 0x0A and 0x0D.
- **Nesting:**
  - `(`, `[`, `{` increment depth.
  - `)`, `]`, `}` decrement it.
  - Bracket types are not matched.
  - Increment at maximum depth sets `err` and saturates.
- **Hold register:** one character plus a `sp_pend` flag. The last non-space character is held until its successor is known, so `m_last` can be set on it.
- **IN_LIST, per accepted byte c:**
  - **Whitespace:**
    - If hold is empty: dropped.
    - Otherwise: set `sp_pend`.
  - **`,` at depth 1:**
    - If hold is full: push held char with `m_last`=1, then idx++.
    - If hold is empty (empty port): set `err`; no bytes emitted and idx unchanged.
    - In both cases, clear `sp_pend`.
  - **`)` at depth 1:**
    - Behaves as the depth-1 comma case, but without setting `err` when hold is empty.
    - `port_count` = idx+1 if a segment was pushed, else idx.
    - Go to FLUSH.
  - **Any other byte, `sp_pend`=0:**
    - Push held char (if any) with `m_last`=0.
    - Hold ← c; depth updates as above.
  - **Any other byte, `sp_pend`=1:**
    - Push held char; hold ← 0x20; clear `sp_pend`.
    - c is not accepted; go to SPACE_STALL.
- **SPACE_STALL:** accept c, push the held 0x20, hold ← c, return to IN_LIST.
- **`s_last` in IN_LIST or SPACE_STALL:** set `err`, discard hold, go to WAIT_OPEN without `done`.
- **FLUSH:** when the output register is empty, pulse `done` and go to TAIL.
- **TAIL:** discard bytes; the byte with `s_last` returns to WAIT_OPEN.
- **idx wrap:** idx wraps modulo 2^CNT_W; no error is raised.

## Timing
- **Reset values:** `s_ready`=0 during reset and 1 afterwards, `m_valid`=0, `m_data`=0, `m_last`=0, `m_idx`=0, `done`=0, `port_count`=0, `err`=0. State is WAIT_OPEN with depth=0.
- **Output register:** single-entry.
  - `m_valid` is held, and `m_data`/`m_last`/`m_idx` are stable, until `m_ready`.
  - `s_ready` = (`!m_valid || m_ready`) && state≠FLUSH.
  - In IN_LIST, `s_ready` is also held low in the cycle a space push is pending.
- **Latency:** a character appears on `m_data` one cycle after its *successor* (or the terminating `,`/`)`) is accepted.
- **Throughput:** one byte per cycle. Each collapsed whitespace run inside a port costs one extra input cycle.
- **`done` timing:** `done` rises no earlier than the cycle after the final `m_last` byte is accepted downstream.
- **Mid-operation reset:** `rst_n` low at any time clears all state immediately. A partially emitted segment is abandoned with no `m_last`.

## Test plan
- **Basic split:** stream `(a, b)` → `a` (`m_last`=1, idx0), then `b` (`m_last`=1, idx1); `done` pulse with `port_count`=2; `err`=0.
- **Whitespace normalisation:** `(  logic  [7:0]\tp ,\n q )` → segment 0 is `logic [7:0] p` with `m_last` only on `p` (13 bytes); segment 1 is `q`.
- **Nested separators:** `((* x, y *) logic p, U #(1, , 3) q)` → exactly 2 segments, the second being `U #(1, , 3) q`; commas inside nesting do not split.
- **Empty list and empty port:**
  - `( )` → no bytes, `done` with `port_count`=0, `err`=0.
  - `(a,,b)` → segments `a`, `b` with idx 0 and 1, and `err`=1.
- **Backpressure:** `m_ready` low for 5 cycles mid-segment → `m_data`/`m_idx` stable, `s_ready`=0, no byte lost or duplicated after release.
- **Abort and reset:**
  - `s_last` on `b` of `(a, b` → `err`=1, no `done`.
  - `rst_n` pulsed low mid-segment → all outputs at reset values; next `(c)` → `c` idx0, `port_count`=1.

Source files
------------

// File: rtl/sv_port_list_splitter.sv
// Splits a SystemVerilog port list "( ... )" into one whitespace-normalised byte segment per top-level port.
// Output lags input by one accepted byte (held char); single output register, s_ready drops when it is full.
module sv_port_list_splitter #(
  parameter int DEPTH_W = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic [CNT_W-1:0] m_idx,
  output logic             done,
  output logic [CNT_W-1:0] port_count,
  output logic             err
);

  typedef enum logic [2:0] {WAIT_OPEN, IN_LIST, SPACE_STALL, FLUSH, TAIL} state_t;

  state_t             r_state, w_state_nxt;
  logic [DEPTH_W-1:0] r_depth, w_depth_nxt, w_depth_upd;
  logic [CNT_W-1:0]   r_idx, w_idx_nxt, w_cnt_nxt;
  logic [7:0]         r_hold, w_hold_nxt;
  logic               r_hold_vld, w_hold_vld_nxt;
  logic               r_sp_pend, w_sp_pend_nxt;
  logic               w_push, w_push_last, w_done_nxt, w_err_set, w_cnt_ld, w_ovf;
  logic               w_is_ws, w_is_open, w_is_close, w_at_top, w_sep, w_end;
  logic               w_out_free, w_space_hit, w_fire, w_stall_go;

  assign w_is_ws    = (s_data == 8'h20) || (s_data == 8'h09) || (s_data == 8'h0A) || (s_data == 8'h0D);
  assign w_is_open  = (s_data == "(") || (s_data == "[") || (s_data == "{");
  assign w_is_close = (s_data == ")") || (s_data == "]") || (s_data == "}");
  assign w_at_top   = (r_depth == DEPTH_W'(1));
  assign w_sep      = w_at_top && (s_data == ",");
  assign w_end      = w_at_top && (s_data == ")");
  assign w_out_free = !m_valid || m_ready;

  // A collapsed whitespace run is emitted before the byte that follows it, so that byte waits one cycle.
  assign w_space_hit = (r_state == IN_LIST) && r_sp_pend && !w_is_ws && !w_sep && !w_end;
  assign s_ready     = rst_n && w_out_free && (r_state != FLUSH) && !w_space_hit;
  assign w_fire      = s_valid && s_ready;
  assign w_stall_go  = s_valid && w_out_free && w_space_hit;

  assign w_ovf       = w_is_open && (r_depth == {DEPTH_W{1'b1}});
  assign w_depth_upd = w_is_open  ? (w_ovf ? r_depth : r_depth + DEPTH_W'(1)) :
                       w_is_close ? r_depth - DEPTH_W'(1) : r_depth;

  always_comb begin
    w_state_nxt    = r_state;
    w_depth_nxt    = r_depth;
    w_idx_nxt      = r_idx;
    w_hold_nxt     = r_hold;
    w_hold_vld_nxt = r_hold_vld;
    w_sp_pend_nxt  = r_sp_pend;
    w_push         = 1'b0;
    w_push_last    = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_set      = 1'b0;
    w_cnt_ld       = 1'b0;
    w_cnt_nxt      = r_idx + CNT_W'(r_hold_vld);
    case (r_state)
      WAIT_OPEN: begin
        if (w_fire && s_data == "(") begin
          w_depth_nxt    = DEPTH_W'(1);
          w_idx_nxt      = '0;
          w_hold_vld_nxt = 1'b0;
          w_sp_pend_nxt  = 1'b0;
          w_state_nxt    = IN_LIST;
        end
      end
      IN_LIST: begin
        if (w_stall_go) begin
          w_push        = 1'b1;
          w_hold_nxt    = 8'h20;
          w_sp_pend_nxt = 1'b0;
          w_state_nxt   = SPACE_STALL;
        end else if (w_fire) begin
          if (s_last) begin
            w_err_set      = 1'b1;
            w_hold_vld_nxt = 1'b0;
            w_sp_pend_nxt  = 1'b0;
            w_depth_nxt    = '0;
            w_state_nxt    = WAIT_OPEN;
          end else if (w_is_ws) begin
            w_sp_pend_nxt = r_hold_vld;
          end else if (w_sep || w_end) begin
            w_push         = r_hold_vld;
            w_push_last    = 1'b1;
            w_hold_vld_nxt = 1'b0;
            w_sp_pend_nxt  = 1'b0;
            if (w_end) begin
              w_cnt_ld    = 1'b1;
              w_depth_nxt = '0;
              w_state_nxt = FLUSH;
            end else if (r_hold_vld) begin
              w_idx_nxt = r_idx + CNT_W'(1);
            end else begin
              w_err_set = 1'b1;
            end
          end else begin
            w_push         = r_hold_vld;
            w_hold_nxt     = s_data;
            w_hold_vld_nxt = 1'b1;
            w_depth_nxt    = w_depth_upd;
            w_err_set      = w_ovf;
          end
        end
      end
      SPACE_STALL: begin
        if (w_fire) begin
          if (s_last) begin
            w_err_set      = 1'b1;
            w_hold_vld_nxt = 1'b0;
            w_depth_nxt    = '0;
            w_state_nxt    = WAIT_OPEN;
          end else begin
            w_push         = 1'b1;
            w_hold_nxt     = s_data;
            w_hold_vld_nxt = 1'b1;
            w_depth_nxt    = w_depth_upd;
            w_err_set      = w_ovf;
            w_state_nxt    = IN_LIST;
          end
        end
      end
      FLUSH: begin
        if (!m_valid) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (w_fire && s_last) w_state_nxt = WAIT_OPEN;
      end
      default: w_state_nxt = WAIT_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT_OPEN;
      r_depth    <= '0;
      r_idx      <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_sp_pend  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_depth    <= w_depth_nxt;
      r_idx      <= w_idx_nxt;
      r_hold     <= w_hold_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_sp_pend  <= w_sp_pend_nxt;
    end
  end

  // Output register keeps data/last/idx frozen while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      m_idx      <= '0;
      done       <= 1'b0;
      port_count <= '0;
      err        <= 1'b0;
    end else begin
      if (w_push) begin
        m_valid <= 1'b1;
        m_data  <= r_hold;
        m_last  <= w_push_last;
        m_idx   <= r_idx;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      done <= w_done_nxt;
      if (w_cnt_ld)  port_count <= w_cnt_nxt;
      if (w_err_set) err <= 1'b1;
    end
  end

endmodule
